// File: rtl/div_c_pkg.sv
// Shared types and helpers for the sequential complex divider.
// DIV_C_SAT_EN selects saturating quotient packing instead of two's-complement wrap.
package div_c_pkg;

   localparam int unsigned DEF_PART_LEN = 8;

   typedef enum logic [1:0] {
      IDLE,
      PREP,
      DIV,
      DONE
   } state_e;

   // Applies the sign to a quotient magnitude and reduces it to plen bits.
   // The result is returned zero-extended; callers keep the low plen bits.
   function automatic logic [31:0] pack_part(input logic        neg,
                                             input logic [30:0] mag,
                                             input int unsigned plen);
      logic signed [31:0] sq;
      logic        [31:0] mask;
      sq = neg ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
`ifdef DIV_C_SAT_EN
      if (sq > ((32'sd1 <<< (plen - 1)) - 32'sd1)) begin
         sq = (32'sd1 <<< (plen - 1)) - 32'sd1;
      end else if (sq < -(32'sd1 <<< (plen - 1))) begin
         sq = -(32'sd1 <<< (plen - 1));
      end
`endif
      mask = (32'd1 << plen) - 32'd1;
      return sq & mask;
   endfunction

endpackage

// File: rtl/div_c_seq_udiv_core.sv
// Unsigned restoring divider datapath: one quotient bit per enabled cycle, MSB first.
module udiv_core
   import div_c_pkg::*;
#(
   parameter int unsigned W = 2 * DEF_PART_LEN
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic         en_i,
   input  logic [W-1:0] dvd_i,
   input  logic [W-1:0] dvs_i,
   output logic [W-1:0] quo_o
);

   logic [W-1:0] rem_q, rem_d;
   // Dividend bits shift out of the top while quotient bits shift in at the bottom.
   logic [W-1:0] qd_q, qd_d;
   logic [W:0]   rem_sh;
   logic         ge;

   always_comb begin
      rem_d  = rem_q;
      qd_d   = qd_q;
      rem_sh = {rem_q, qd_q[W-1]};
      ge     = (rem_sh >= {1'b0, dvs_i});
      if (load_i) begin
         rem_d = '0;
         qd_d  = dvd_i;
      end else if (en_i) begin
         rem_d = ge ? (rem_sh[W-1:0] - dvs_i) : rem_sh[W-1:0];
         qd_d  = {qd_q[W-2:0], ge};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q <= '0;
         qd_q  <= '0;
      end else begin
         rem_q <= rem_d;
         qd_q  <= qd_d;
      end
   end

   assign quo_o = qd_q;

endmodule

// File: rtl/div_c_seq.sv
// Sequential complex divider res = a*conj(b)/|b|^2 behind valid/ready handshakes.
// Define DIV_C_SAT_EN to saturate each quotient field instead of wrapping it.
module div_c_seq
   import div_c_pkg::*;
#(
   parameter int unsigned PART_LEN = DEF_PART_LEN
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2*PART_LEN-1:0] a,
   input  logic [2*PART_LEN-1:0] b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [2*PART_LEN-1:0] res,
   output logic                  div_zero
);

   localparam int unsigned W  = 2 * PART_LEN;
   localparam int unsigned CW = $clog2(W);

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic signed [W:0] num_r_q, num_i_q, num_r_d, num_i_d;
   logic [W-1:0]    den_q, den_d;
   logic            accept, load, step;

   logic signed [PART_LEN-1:0] ra, ia, rb, ib;
   logic signed [W:0]          rax, iax, rbx, ibx;
   logic signed [W-1:0]        rbw, ibw;
   logic [W-1:0]               mag_r, mag_i, quo_r, quo_i;
   logic [PART_LEN-1:0]        rq, iq;
   logic                       den_zero;

   assign ra  = a[W-1:PART_LEN];
   assign ia  = a[PART_LEN-1:0];
   assign rb  = b[W-1:PART_LEN];
   assign ib  = b[PART_LEN-1:0];
   assign rax = (W+1)'(ra);
   assign iax = (W+1)'(ia);
   assign rbx = (W+1)'(rb);
   assign ibx = (W+1)'(ib);
   assign rbw = W'(rb);
   assign ibw = W'(ib);

   // Operands are only guaranteed during the accepting cycle, so the
   // numerators and |b|^2 are formed and captured on that edge.
   assign num_r_d = rax * rbx + iax * ibx;
   assign num_i_d = iax * rbx - rax * ibx;
   assign den_d   = rbw * rbw + ibw * ibw;

   assign mag_r = num_r_q[W] ? (~num_r_q[W-1:0] + W'(1)) : num_r_q[W-1:0];
   assign mag_i = num_i_q[W] ? (~num_i_q[W-1:0] + W'(1)) : num_i_q[W-1:0];

   udiv_core #(.W(W)) u_div_re (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (load),
      .en_i   (step),
      .dvd_i  (mag_r),
      .dvs_i  (den_q),
      .quo_o  (quo_r)
   );

   udiv_core #(.W(W)) u_div_im (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (load),
      .en_i   (step),
      .dvd_i  (mag_i),
      .dvs_i  (den_q),
      .quo_o  (quo_i)
   );

   assign rq       = PART_LEN'(pack_part(num_r_q[W], {{(31-W){1'b0}}, quo_r}, PART_LEN));
   assign iq       = PART_LEN'(pack_part(num_i_q[W], {{(31-W){1'b0}}, quo_i}, PART_LEN));
   assign den_zero = (den_q == '0);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      accept    = 1'b0;
      load      = 1'b0;
      step      = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      div_zero  = 1'b0;
      res       = '0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept  = 1'b1;
               state_d = PREP;
            end
         end
         PREP: begin
            load    = 1'b1;
            cnt_d   = '0;
            state_d = DIV;
         end
         DIV: begin
            step = 1'b1;
            if (cnt_q == CW'(W - 1)) begin
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            out_valid = 1'b1;
            div_zero  = den_zero;
            res       = den_zero ? '0 : {rq, iq};
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         num_r_q <= '0;
         num_i_q <= '0;
         den_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            num_r_q <= num_r_d;
            num_i_q <= num_i_d;
            den_q   <= den_d;
         end
      end
   end

endmodule
